// File: rtl/softmax_max_buf.sv
// softmax_max_buf: buffers one input vector while tracking its signed maximum,
// then replays each element beside that maximum so the downstream range-reduction
// unit computes (x - max) * const, which is never positive.
module softmax_max_buf #(
    parameter int Bf              = 8,
    parameter int FIX_POINT_WIDTH = 16,
    parameter int DEPTH           = 64,
    parameter int CNT_W           = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 cfg_s_mult,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [FIX_POINT_WIDTH-1:0] s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIX_POINT_WIDTH-1:0] m_x,
    output logic [FIX_POINT_WIDTH-1:0] m_max,
    output logic                       m_last,
    output logic                       s_mux,
    output logic [2:0]                 s_mult,
    output logic [CNT_W-1:0]           vec_len,
    output logic                       err_ovf
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reject parameter sets the datapath cannot represent.
    if (DEPTH < 2) begin : g_bad_depth
        $error("softmax_max_buf: DEPTH must be at least 2");
    end
    if (Bf >= FIX_POINT_WIDTH) begin : g_bad_bf
        $error("softmax_max_buf: Bf must be smaller than FIX_POINT_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        REPLAY
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [FIX_POINT_WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]           wr;
    logic [CNT_W-1:0]           rd;
    logic [FIX_POINT_WIDTH-1:0] max_q;
    logic                       s_fire;
    logic                       m_fire;
    logic                       buf_full;

    // Handshake qualifiers; the final slot closes the vector even without s_last.
    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_valid && m_ready;
    assign buf_full = (wr == CNT_W'(DEPTH - 1));

    // The ru unit is always run in subtract-max mode.
    assign s_mux = 1'b1;
    assign m_max = max_q;
    assign m_x   = mem[rd[ADDR_W-1:0]];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; load and replay never overlap.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        unique case (state)
            IDLE: begin
                s_ready = rst_n;
                if (s_fire) state_nxt = s_last ? REPLAY : LOAD;
            end
            LOAD: begin
                s_ready = rst_n;
                if (s_fire && (s_last || buf_full)) state_nxt = REPLAY;
            end
            REPLAY: begin
                m_valid = 1'b1;
                m_last  = (rd == vec_len - CNT_W'(1));
                if (m_fire && m_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Element storage, written on every accepted input.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately left out of reset; every slot is written
        // before it is replayed, so clearing it would only cost reset fanout.
        if (s_fire) mem[wr[ADDR_W-1:0]] <= s_data;
    end

    // Counters, running maximum, per-vector config and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr      <= '0;
            rd      <= '0;
            max_q   <= '0;
            s_mult  <= '0;
            vec_len <= '0;
            err_ovf <= 1'b0;
        end else begin
            err_ovf <= 1'b0;
            if (s_fire) begin
                if (state == IDLE) begin
                    // First element seeds the maximum and latches the vector config.
                    max_q  <= s_data;
                    s_mult <= cfg_s_mult;
                    wr     <= CNT_W'(1);
                    if (s_last) vec_len <= CNT_W'(1);
                end else begin
                    wr <= wr + CNT_W'(1);
                    if ($signed(s_data) > $signed(max_q)) max_q <= s_data;
                    if (s_last || buf_full) begin
                        vec_len <= wr + CNT_W'(1);
                        err_ovf <= !s_last;
                    end
                end
            end
            if (state == REPLAY && m_fire) begin
                if (m_last) begin
                    rd <= '0;
                    wr <= '0;
                end else begin
                    rd <= rd + CNT_W'(1);
                end
            end
        end
    end

endmodule
